fcs_check: RTL
==============

Name: fcs_check

Overview:
- Frame check sequence (CRC-32) verifier for the Ethernet receive path.
- Taps the dibit AXI-style stream leaving the ether stage, in parallel with bitorder, in on-wire LSb-first order.
- Emits a one-cycle verdict at end of frame: good or kill.
- Downstream logic (aggregate or a later commit stage) uses the verdict to accept or drop the word it collected.

Parameters:
- MIN_BYTES, 0: frames with fewer bytes than this (FCS included) are killed; 0 disables the check.
- CNT_W, 16: width of the saturating good and bad frame counters.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous reset, active-low; clears all state immediately.
- axiiv  input  1  dibit valid from ether; high for the whole frame, including FCS.
- axiid  input  2  dibit, on-wire order; axiid[0] is the earlier bit in time.
- done  output  1  one-cycle pulse when a frame has been judged.
- kill  output  1  meaningful only while done=1; 1 = frame bad.
- good_count  output  CNT_W  number of frames with done=1 and kill=0; saturates at all-ones.
- bad_count  output  CNT_W  number of frames with done=1 and kill=1; saturates at all-ones.

Behaviour:
- Reset state (rst=0):
  - done=0, kill=0, good_count=0, bad_count=0.
  - CRC register = 32'hFFFF_FFFF, dibit counter = 0, state = IDLE.
  - Takes effect without a clock edge.
- CRC definition:
  - Reflected CRC-32, polynomial 32'hEDB8_8320, initial value all-ones.
  - Two bits per clock: axiid[0] is shifted in first, then axiid[1].
  - No final XOR is applied internally.
  - Over a correct frame with FCS appended, the register ends at the residue 32'hDEBB_20E3.
- Dibit counter: counts valid dibits in a frame. Its width must hold 4*max(MIN_BYTES, 1518) without wrap; it saturates at all-ones.
- State machine:
  - IDLE: axiiv=1 → load the CRC as init updated with this dibit, set count=1, go to RUN. axiiv=0 → stay.
  - RUN: axiiv=1 → update CRC, count+1. axiiv=0 → go to IDLE and register the verdict.
  - The verdict is visible as done=1 on the cycle after the first axiiv=0 sample, i.e. a latency of 1 cycle from the end of frame.
- Verdict: kill=1 if any of the following hold, otherwise kill=0:
  - the CRC residue is not 32'hDEBB_20E3;
  - count[1:0] is nonzero (byte misalignment);
  - MIN_BYTES>0 and count/4 < MIN_BYTES.
- Counters:
  - On done, increment good_count or bad_count.
  - Both hold at all-ones once saturated.
  - Neither changes at any other time.
- done and kill:
  - Both deassert the cycle after the pulse.
  - kill is forced to 0 whenever done=0.
- Back-to-back frames: if axiiv rises on the same cycle done is high, the new frame starts cleanly from init. The verdict for the previous frame is unaffected.
- A one-dibit frame (valid for a single cycle) produces done=1, kill=1.
- Reset mid-frame: no done is produced for the aborted frame and counters clear. The next axiiv=1 after release starts a fresh frame.
- No backpressure exists: the block never stalls its input and must accept a dibit every cycle.

Test Plan:
1. Bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB, each sent LSb-first as 4 dibits (52 cycles), then axiiv=0 → done=1 one cycle after the fall, kill=0, good_count=1.
2. Same frame with bit 0 of byte 35 inverted → done=1, kill=1, bad_count=1, good_count unchanged.
3. Frame 1 plus one extra dibit 2'b00 (53 dibits) → kill=1 (alignment). Single-dibit frame → done=1, kill=1.
4. MIN_BYTES=64 with frame 1 → kill=1. The same 13-byte payload padded to a 64-byte frame with correct FCS → kill=0.
5. Frame 1 back-to-back with one idle cycle between copies, repeated 3 times → three done pulses, each kill=0, good_count=3.
6. rst driven low at dibit 20 of frame 1, then released → done stays 0 and counters read 0. The next full frame 1 → done with kill=0, good_count=1.
7. CNT_W=2 with five bad frames → bad_count reads 3 and holds.

Source files
------------

// File: rtl/fcs_check.sv
// -----------------------------------------------------------------------------
// fcs_check
//   CRC-32 frame check sequence verifier for the Ethernet receive path. Taps
//   the dibit stream leaving the ether stage, in on-wire LSb-first order, and
//   issues a one-cycle verdict (good or kill) one cycle after each frame ends.
//
//   Stream handshake: there is no ready. A dibit is transferred on every
//   rising clk edge where axiiv=1. A frame is a maximal run of axiiv=1 cycles,
//   and the block accepts a dibit every cycle without stalling.
//
// Parameters
//   MIN_BYTES  frames shorter than this many bytes (FCS included) are killed;
//              0 disables the length check
//   CNT_W      width of the saturating good/bad frame counters
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   axiiv        dibit valid, high for the whole frame including the FCS
//   axiid[1:0]   dibit; axiid[0] is the earlier bit on the wire
//   done         one-cycle pulse when a frame has been judged
//   kill         frame bad; only ever high together with done
//   good_count   frames judged good, saturating
//   bad_count    frames judged bad, saturating
//   dbg_state_o  current FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module fcs_check #(
   parameter int MIN_BYTES = 0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             axiiv,
   input  logic [1:0]       axiid,
   output logic             done,
   output logic             kill,
   output logic [CNT_W-1:0] good_count,
   output logic [CNT_W-1:0] bad_count,
   output logic             dbg_state_o
);

   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   // The dibit counter must reach the longest frame we care about without
   // wrapping, so it is sized from the larger of MIN_BYTES and a max frame.
   localparam int MAX_BYTES = (MIN_BYTES > 1518) ? MIN_BYTES : 1518;
   localparam int DW        = $clog2(4 * MAX_BYTES + 1);

   localparam logic [DW-1:0]    MIN_DIBITS = DW'(4 * MIN_BYTES);
   localparam logic [DW-1:0]    DIB_ONE    = DW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [31:0]      crc_q, crc_d;
   logic [DW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             kill_q, kill_d;
   logic [CNT_W-1:0] good_q, good_d;
   logic [CNT_W-1:0] bad_q, bad_d;
   logic             frame_bad;

   // Reflected CRC-32 advanced by two bits, axiid[0] first.
   function automatic logic [31:0] crc_dibit(input logic [31:0] c,
                                             input logic [1:0]  d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 2; i++) begin
         r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
      end
      return r;
   endfunction

   // count/4 < MIN_BYTES is evaluated as count < 4*MIN_BYTES.
   always_comb begin
      frame_bad = (crc_q != CRC_RESIDUE) || (cnt_q[1:0] != 2'b00);
      if ((MIN_BYTES > 0) && (cnt_q < MIN_DIBITS)) begin
         frame_bad = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      kill_d  = 1'b0;
      good_d  = good_q;
      bad_d   = bad_q;
      case (state_q)
         IDLE: begin
            // Always restart from init, so a frame starting on the done
            // cycle of its predecessor is unaffected by it.
            if (axiiv) begin
               crc_d   = crc_dibit(CRC_INIT, axiid);
               cnt_d   = DIB_ONE;
               state_d = RUN;
            end
         end
         RUN: begin
            if (axiiv) begin
               crc_d = crc_dibit(crc_q, axiid);
               if (!(&cnt_q)) begin
                  cnt_d = cnt_q + DIB_ONE;
               end
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
               kill_d  = frame_bad;
               if (frame_bad) begin
                  if (!(&bad_q)) bad_d = bad_q + CNT_ONE;
               end else begin
                  if (!(&good_q)) good_d = good_q + CNT_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         crc_q   <= CRC_INIT;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         kill_q  <= 1'b0;
         good_q  <= '0;
         bad_q   <= '0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         kill_q  <= kill_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
      end
   end

   assign done        = done_q;
   assign kill        = kill_q & done_q;
   assign good_count  = good_q;
   assign bad_count   = bad_q;
   assign dbg_state_o = state_q;

endmodule
